// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, issues imem requests, loads the IF/ID register.
// Latency: 1 cycle from PC to IF/ID with a zero-wait memory (one instruction per cycle).
// Backpressure: stall_id withholds the request and freezes PC/IF/ID; imem_ready=0 inserts bubbles.
module if_fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC   = 16'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_id,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic        ifid_valid,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_pc_next,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic        redirect_take;
    logic        halt_take;
    logic        accept;

    // Qualified events: redirect and halt are dead once halted; redirect beats halt.
    always_comb begin
        pc_inc        = pc + PC_INC;
        redirect_take = redirect_valid & (state != S_HALTED);
        halt_take     = halt & ~redirect_valid & (state != S_HALTED);
        accept        = imem_req & imem_ready;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: redirect > halt > stall > accept > wait; HALTED only leaves via reset.
    always_comb begin
        state_nxt = state;
        if (state == S_HALTED) begin
            state_nxt = S_HALTED;
        end else if (redirect_take) begin
            state_nxt = S_FETCH;
        end else if (halt_take) begin
            state_nxt = S_HALTED;
        end else if (stall_id) begin
            state_nxt = state;
        end else if (imem_ready) begin
            state_nxt = S_FETCH;
        end else begin
            state_nxt = S_WAIT;
        end
    end

    // Outputs: request is suppressed in reset, when halted and when decode stalls.
    always_comb begin
        imem_req  = rst_n & (state != S_HALTED) & ~stall_id;
        imem_addr = pc;
        halted    = (state == S_HALTED);
    end

    // PC and IF/ID register, same priority as the state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            ifid_valid   <= 1'b0;
            ifid_instr   <= 16'h0000;
            ifid_pc      <= 16'h0000;
            ifid_pc_next <= 16'h0000;
        end else if (redirect_take) begin
            pc         <= redirect_pc;
            ifid_valid <= 1'b0;
        end else if (halt_take) begin
            ifid_valid <= 1'b0;
        end else if (accept) begin
            ifid_instr   <= imem_rdata;
            ifid_pc      <= pc;
            ifid_pc_next <= pc_inc;
            ifid_valid   <= 1'b1;
            pc           <= pc_inc;
        end else if (imem_req) begin
            ifid_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random stall/wait/redirect traffic.
// Latency: checks each cycle half a period after the rising edge against a cycle model.
// Backpressure: stall_id and imem_ready are driven as stimulus; the model tracks their effect.
module tb_if_fetch_stage;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_id = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_ready = 1'b0;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_next;
    logic        halted;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural view only (PC, halted flag, IF/ID contents).
    logic [15:0] m_pc;
    logic        m_halted;
    logic        m_vld;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;
    logic [15:0] m_inext;

    if_fetch_stage #(.RESET_PC(RST_PC), .PC_INC(16'd2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_id      (stall_id),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_pc_next  (ifid_pc_next),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic exp_req;
        exp_req = rst_n & ~m_halted & ~stall_id;
        chk("imem_req",     {15'b0, imem_req},   {15'b0, exp_req});
        chk("imem_addr",    imem_addr,           m_pc);
        chk("halted",       {15'b0, halted},     {15'b0, m_halted});
        chk("ifid_valid",   {15'b0, ifid_valid}, {15'b0, m_vld});
        chk("ifid_instr",   ifid_instr,          m_instr);
        chk("ifid_pc",      ifid_pc,             m_ipc);
        chk("ifid_pc_next", ifid_pc_next,        m_inext);
    endtask

    task automatic model_reset();
        m_pc     = RST_PC;
        m_halted = 1'b0;
        m_vld    = 1'b0;
        m_instr  = 16'h0000;
        m_ipc    = 16'h0000;
        m_inext  = 16'h0000;
    endtask

    // Called at a falling edge: pulse reset asynchronously, check, release at the next falling edge.
    task automatic do_reset();
        rst_n          = 1'b0;
        stall_id       = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        imem_ready     = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle of stimulus, starting and ending at a falling edge.
    task automatic cyc(input logic st, input logic rv, input logic [15:0] rpc,
                       input logic hl, input logic rdy);
        stall_id       = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = hl;
        imem_ready     = rdy;
        imem_rdata     = rdy ? mem_word(m_pc) : 16'($urandom);
        #1;
        check_all();
        if (!m_halted) begin
            if (rv) begin
                m_pc  = rpc;
                m_vld = 1'b0;
            end else if (hl) begin
                m_halted = 1'b1;
                m_vld    = 1'b0;
            end else if (st) begin
                // everything holds
            end else if (rdy) begin
                m_instr = mem_word(m_pc);
                m_ipc   = m_pc;
                m_inext = m_pc + 16'd2;
                m_vld   = 1'b1;
                m_pc    = m_pc + 16'd2;
            end else begin
                m_vld = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Zero-wait streaming from reset.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

        // Stall after pc=4 is in IF/ID, then resume; then a 2-cycle wait at pc=8.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

        // Redirect while waiting and stalled.
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

        // Wrap at the top of the address space, and an odd target passed through.
        cyc(1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 16'h0123, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

        // Reset in the middle of a wait.
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        do_reset();
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

        // Random stall / wait / redirect traffic.
        for (int i = 0; i < 400; i++) begin
            logic st, rv, hl, rdy;
            logic [15:0] rpc;
            st  = ($urandom_range(99, 0) < 20);
            rdy = ($urandom_range(99, 0) < 70);
            rv  = ($urandom_range(99, 0) < 6);
            hl  = rv & ($urandom_range(99, 0) < 30);
            rpc = 16'($urandom) & 16'hFFFE;
            cyc(st, rv, rpc, hl, rdy);
        end

        // Halt is sticky: redirect and stall are ignored until reset.
        cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 16'h0080, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

        // Reset out of HALTED and during a stall.
        do_reset();
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        do_reset();
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
